// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V front end: datapath defaults, the NOP encoding
// and the 2-bit fetch state encoding.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_HOLD = 2'd2;

  // Instruction addresses must be word aligned (no compressed extension).
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating count of WAIT cycles without a memory response; flags the cycle whose
// increment would bring the count to TIMEOUT.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(TIMEOUT))) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Combinational so the fault is taken on the same edge the count would reach TIMEOUT.
  assign expired = enable && (count_reg >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns PC and IR, runs one req/valid
// transaction per instruction and holds the word until the next PC is committed.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            pc_update,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fault
);

  fetch_state_t    state_reg;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     instr_reg;
  logic            fault_reg;
  logic            timer_clear;
  logic            timer_en;
  logic            timer_expired;

  assign timer_clear = (state_reg != ST_WAIT);
  assign timer_en    = (state_reg == ST_WAIT) && !imem_valid;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (fetch_en && !fault_reg) state_next = ST_WAIT;
      ST_WAIT: begin
        // A response on the expiry edge still wins over the timeout.
        if (imem_valid)         state_next = ST_HOLD;
        else if (timer_expired) state_next = ST_IDLE;
      end
      ST_HOLD: if (pc_update) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_reg)
      ST_WAIT: imem_req    = 1'b1;
      ST_HOLD: instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign pc_plus4 = pc_reg + XLEN'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      fault_reg <= 1'b0;
    end else begin
      if (state_reg == ST_WAIT) begin
        if (imem_valid)         instr_reg <= imem_rdata;
        else if (timer_expired) fault_reg <= 1'b1;
      end
      if ((state_reg == ST_HOLD) && pc_update) begin
        if (!redirect)                             pc_reg    <= pc_plus4;
        else if (is_word_aligned(redirect_pc[1:0])) pc_reg    <= redirect_pc;
        else                                       fault_reg <= 1'b1;
      end
    end
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign instr     = instr_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed expectations checked with
// immediate assertions after each step.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_update;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .pc_update   (pc_update),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // fetch_en for one edge, then lat idle WAIT cycles before a one-cycle response.
  task automatic do_fetch(input logic [31:0] data, input int lat);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    repeat (lat) tick();
    imem_valid = 1'b1;
    imem_rdata = data;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic commit(input logic redir, input logic [31:0] target);
    pc_update   = 1'b1;
    redirect    = redir;
    redirect_pc = target;
    tick();
    pc_update   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cycles;
    rst = 1'b1; fetch_en = 1'b0; pc_update = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0; imem_valid = 1'b0;
    #2;

    // Reset state
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);

    // 1. Basic fetch, response three cycles after req
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("t1_req_high", {31'b0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    tick(); tick(); tick();
    imem_valid = 1'b1; imem_rdata = 32'h0020_81B3;
    chk("t1_valid_before", {31'b0, instr_valid}, 32'd0);
    tick();
    imem_valid = 1'b0;
    chk("t1_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h0020_81B3);
    chk("t1_req_low", {31'b0, imem_req}, 32'd0);
    chk("t1_pc", pc, 32'h0);

    // 2. Sequential commit, then wrap from FFFF_FFFC
    commit(1'b0, 32'h0);
    chk("t2_pc_seq", pc, 32'h4);
    chk("t2_valid_drop", {31'b0, instr_valid}, 32'd0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("t2_addr4", imem_addr, 32'h4);
    chk("t2_req4", {31'b0, imem_req}, 32'd1);
    imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_valid = 1'b0;
    chk("t2_instr_min_lat", instr, 32'h1111_1111);
    commit(1'b1, 32'hFFFF_FFFC);
    chk("t2_pc_top", pc, 32'hFFFF_FFFC);
    chk("t2_pc_plus4_wrap", pc_plus4, 32'h0);
    do_fetch(32'h2222_2222, 1);
    commit(1'b0, 32'h0);
    chk("t2_pc_wrap", pc, 32'h0);
    chk("t2_fault_wrap", {31'b0, fault}, 32'd0);

    // 3. Aligned redirect, then misaligned redirect faults
    do_fetch(32'h3333_3333, 0);
    commit(1'b1, 32'h0000_0100);
    chk("t3_pc_redir", pc, 32'h100);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("t3_addr_redir", imem_addr, 32'h100);
    imem_valid = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    imem_valid = 1'b0;
    commit(1'b1, 32'h0000_0102);
    chk("t3_pc_unchanged", pc, 32'h100);
    chk("t3_fault", {31'b0, fault}, 32'd1);
    chk("t3_valid_after", {31'b0, instr_valid}, 32'd0);
    fetch_en = 1'b1;
    tick();
    chk("t3_blocked_req", {31'b0, imem_req}, 32'd0);
    tick();
    fetch_en = 1'b0;
    chk("t3_blocked_req2", {31'b0, imem_req}, 32'd0);

    // 4. Memory never responds -> timeout after exactly 16 request cycles
    do_reset();
    chk("t4_fault_cleared", {31'b0, fault}, 32'd0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) req_cycles++;
      tick();
    end
    chk("t4_req_cycles", req_cycles, 32'd16);
    chk("t4_fault", {31'b0, fault}, 32'd1);
    chk("t4_instr_nop", instr, NOP);
    chk("t4_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("t4_req_low", {31'b0, imem_req}, 32'd0);

    // Boundary: response on the 16th WAIT cycle is accepted without fault
    do_reset();
    do_fetch(32'h5555_5555, 15);
    chk("tb_edge_valid", {31'b0, instr_valid}, 32'd1);
    chk("tb_edge_instr", instr, 32'h5555_5555);
    chk("tb_edge_fault", {31'b0, fault}, 32'd0);

    // 5. Reset mid-WAIT, late response ignored
    commit(1'b0, 32'h0);
    chk("t5_pc_before", pc, 32'h4);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_req_dropped", {31'b0, imem_req}, 32'd0);
    chk("t5_pc_reset", pc, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'h6666_6666;
    tick();
    imem_valid = 1'b0;
    chk("t5_instr_nop", instr, NOP);
    chk("t5_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_req_still_low", {31'b0, imem_req}, 32'd0);

    // 6. Spurious inputs in IDLE, WAIT, HOLD
    do_reset();
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    pc_update = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    imem_valid = 1'b0; pc_update = 1'b0; redirect = 1'b0;
    chk("t6_idle_instr", instr, NOP);
    chk("t6_idle_pc", pc, 32'h0);
    chk("t6_idle_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_idle_req", {31'b0, imem_req}, 32'd0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    pc_update = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    pc_update = 1'b0; redirect = 1'b0;
    chk("t6_wait_pc", pc, 32'h0);
    chk("t6_wait_req", {31'b0, imem_req}, 32'd1);
    imem_valid = 1'b1; imem_rdata = 32'hAAAA_0001;
    tick();
    imem_rdata = 32'hBBBB_0002;
    fetch_en = 1'b1;
    tick();
    imem_valid = 1'b0; fetch_en = 1'b0;
    chk("t6_hold_instr", instr, 32'hAAAA_0001);
    chk("t6_hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_hold_req", {31'b0, imem_req}, 32'd0);
    fetch_en = 1'b1;
    commit(1'b0, 32'h0);
    chk("t6_upd_wins_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_upd_wins_req", {31'b0, imem_req}, 32'd0);
    chk("t6_upd_wins_pc", pc, 32'h4);
    tick();
    fetch_en = 1'b0;
    chk("t6_next_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("t6_next_fetch_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
